// File: rtl/diaosi_types_pkg.sv
// Shared types for the front end; branch predictor counter encoding and BTB entry layout.
package diaosi_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_t;

   localparam bp_ctr_t BP_CTR_RESET = WNT;
   localparam bp_ctr_t BP_CTR_ALLOC = WT;

   // Layout for the default 16-entry buffer; other sizes declare their own tag width.
   typedef struct packed {
      logic        valid;
      logic [25:0] tag;
      word_t       target;
      bp_ctr_t     ctr;
   } btb_entry_t;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction counter next-state; purely combinational.
module bp_sat_counter
   import diaosi_types_pkg::*;
(
   input  bp_ctr_t cur,
   input  logic    taken,
   output bp_ctr_t nxt
);

   always_comb begin
      nxt = cur;
      unique case (cur)
         SNT: nxt = taken ? WNT : SNT;
         WNT: nxt = taken ? WT  : SNT;
         WT:  nxt = taken ? ST  : WNT;
         ST:  nxt = taken ? ST  : WT;
         default: nxt = cur;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; zero-latency lookup, update on resolve.
// Optional performance counters are built when BP_STATS_EN is defined.
module branch_predictor
   import diaosi_types_pkg::*;
#(
   parameter int ENTRIES = 16
)
(
   input  logic        CLK,
   input  logic        RST,
   input  word_t       fetch_pc,
   output logic        pred_taken,
   output word_t       pred_target,
   input  logic        res_valid,
   input  logic        res_en,
   input  word_t       res_pc,
   input  logic        res_taken,
   input  word_t       res_target,
   input  logic        res_pred_taken,
   input  word_t       res_pred_target,
   output logic        mispredict
`ifdef BP_STATS_EN
   ,
   output logic [31:0] stat_lookups,
   output logic [31:0] stat_mispred
`endif
);

   localparam int IDX  = $clog2(ENTRIES);
   localparam int TAGW = 30 - IDX;

   typedef struct packed {
      logic            valid;
      logic [TAGW-1:0] tag;
      word_t           target;
      bp_ctr_t         ctr;
   } entry_t;

   entry_t btb_q [ENTRIES];

   logic [IDX-1:0]  f_idx, r_idx;
   logic [TAGW-1:0] f_tag, r_tag;
   logic            f_hit, r_hit, commit;
   bp_ctr_t         ctr_nxt;
   logic            unused_pc_bits;

   assign f_idx = fetch_pc[IDX+1:2];
   assign f_tag = fetch_pc[31:IDX+2];
   assign r_idx = res_pc[IDX+1:2];
   assign r_tag = res_pc[31:IDX+2];
   assign unused_pc_bits = ^{fetch_pc[1:0], res_pc[1:0]};

   assign f_hit = btb_q[f_idx].valid && (btb_q[f_idx].tag == f_tag);
   assign r_hit = btb_q[r_idx].valid && (btb_q[r_idx].tag == r_tag);

   // Lookup reads the registered array only, so a same-cycle update is not bypassed.
   assign pred_taken  = f_hit && btb_q[f_idx].ctr[1];
   assign pred_target = pred_taken ? btb_q[f_idx].target : fetch_pc + 32'd4;

   // Independent of res_en so it stays asserted throughout a stall.
   assign mispredict = res_valid &&
                       ((res_taken != res_pred_taken) ||
                        (res_taken && (res_target != res_pred_target)));

   assign commit = res_valid && res_en;

   bp_sat_counter u_ctr (
      .cur   (btb_q[r_idx].ctr),
      .taken (res_taken),
      .nxt   (ctr_nxt)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_q[i].valid  <= 1'b0;
            btb_q[i].tag    <= '0;
            btb_q[i].target <= '0;
            btb_q[i].ctr    <= BP_CTR_RESET;
         end
      end else if (commit) begin
         if (r_hit) begin
            btb_q[r_idx].ctr <= ctr_nxt;
            if (res_taken) begin
               btb_q[r_idx].target <= res_target;
            end
         end else if (res_taken) begin
            btb_q[r_idx].valid  <= 1'b1;
            btb_q[r_idx].tag    <= r_tag;
            btb_q[r_idx].target <= res_target;
            btb_q[r_idx].ctr    <= BP_CTR_ALLOC;
         end
      end
   end

`ifdef BP_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         stat_lookups <= '0;
         stat_mispred <= '0;
      end else begin
         stat_lookups <= stat_lookups + 32'd1;
         if (commit && mispredict) begin
            stat_mispred <= stat_mispred + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// against a table-based reference model. Stat checks are compiled in with BP_STATS_EN.
module tb_branch_predictor;

   localparam int N = 16;

   logic        CLK = 1'b0;
   logic        RST;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        res_valid, res_en, res_taken, res_pred_taken;
   logic [31:0] res_pc, res_target, res_pred_target;
   logic        mispredict;
`ifdef BP_STATS_EN
   logic [31:0] stat_lookups, stat_mispred;
`endif

   branch_predictor #(.ENTRIES(N)) dut (
      .CLK             (CLK),
      .RST             (RST),
      .fetch_pc        (fetch_pc),
      .pred_taken      (pred_taken),
      .pred_target     (pred_target),
      .res_valid       (res_valid),
      .res_en          (res_en),
      .res_pc          (res_pc),
      .res_taken       (res_taken),
      .res_target      (res_target),
      .res_pred_taken  (res_pred_taken),
      .res_pred_target (res_pred_target),
      .mispredict      (mispredict)
`ifdef BP_STATS_EN
      ,
      .stat_lookups    (stat_lookups),
      .stat_mispred    (stat_mispred)
`endif
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: one slot per index, counter kept as a plain integer 0..3.
   bit          m_valid  [N];
   int unsigned m_tag    [N];
   logic [31:0] m_target [N];
   int          m_ctr    [N];
   int unsigned m_look, m_misp;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int slot(input logic [31:0] pc);
      return int'((pc / 4) % N);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return pc / (4 * N);
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
   endfunction

   function automatic bit m_pred_taken(input logic [31:0] pc);
      return m_hit(pc) && (m_ctr[slot(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
      return m_pred_taken(pc) ? m_target[slot(pc)] : pc + 32'd4;
   endfunction

   function automatic bit m_mispredict();
      if (!res_valid) return 1'b0;
      if (res_taken != res_pred_taken) return 1'b1;
      return res_taken && (res_target != res_pred_target);
   endfunction

   task automatic model_edge();
      int i;
      if (RST) begin
         for (int k = 0; k < N; k++) begin
            m_valid[k] = 1'b0; m_tag[k] = 0; m_target[k] = '0; m_ctr[k] = 1;
         end
         m_look = 0;
         m_misp = 0;
      end else begin
         m_look++;
         if (res_valid && res_en) begin
            if (m_mispredict()) m_misp++;
            i = slot(res_pc);
            if (m_hit(res_pc)) begin
               if (res_taken) begin
                  m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                  m_target[i] = res_target;
               end else begin
                  m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
               end
            end else if (res_taken) begin
               m_valid[i] = 1'b1; m_tag[i] = tag_of(res_pc);
               m_target[i] = res_target; m_ctr[i] = 2;
            end
         end
      end
   endtask

   task automatic drive(input logic [31:0] fpc, input logic rv, input logic ren,
                        input logic [31:0] rpc, input logic rt, input logic [31:0] rtgt,
                        input logic rpt, input logic [31:0] rptgt);
      fetch_pc = fpc; res_valid = rv; res_en = ren; res_pc = rpc;
      res_taken = rt; res_target = rtgt; res_pred_taken = rpt; res_pred_target = rptgt;
   endtask

   task automatic idle(input logic [31:0] fpc);
      drive(fpc, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Compare all outputs against the model, then take one clock edge.
   task automatic cycle();
      #1;
      check_val("pred_taken",  {31'b0, pred_taken}, {31'b0, m_pred_taken(fetch_pc)});
      check_val("pred_target", pred_target, m_pred_target(fetch_pc));
      check_val("mispredict",  {31'b0, mispredict}, {31'b0, m_mispredict()});
`ifdef BP_STATS_EN
      if (!$isunknown(stat_lookups)) begin
         check_val("stat_lookups", stat_lookups, m_look);
         check_val("stat_mispred", stat_mispred, m_misp);
      end
`endif
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   initial begin
      RST = 1'b1;
      idle(32'h0);
      @(posedge CLK);
      model_edge();
      #1;
      RST = 1'b0;

      // Cold lookup after reset
      idle(32'h40);
      #1;
      check_val("cold_taken",  {31'b0, pred_taken}, 32'd0);
      check_val("cold_target", pred_target, 32'h44);
      cycle();

      // Allocate 0x40 -> 0x80, mispredicted because predicted not-taken
      drive(32'h40, 1, 1, 32'h40, 1, 32'h80, 0, 32'h44);
      #1;
      check_val("alloc_misp", {31'b0, mispredict}, 32'd1);
      check_val("alloc_nobypass", {31'b0, pred_taken}, 32'd0);
      cycle();
      idle(32'h40);
      #1;
      check_val("alloc_taken",  {31'b0, pred_taken}, 32'd1);
      check_val("alloc_target", pred_target, 32'h80);
      cycle();

      // Hysteresis: weakly taken drops to not-taken after one not-taken commit
      drive(32'h40, 1, 1, 32'h40, 0, 32'h0, 1, 32'h80);
      cycle();
      idle(32'h40);
      #1;
      check_val("hyst_wt_nt", {31'b0, pred_taken}, 32'd0);
      cycle();
      // Drive to strongly taken, then one not-taken commit keeps it taken
      drive(32'h40, 1, 1, 32'h40, 1, 32'h80, 0, 32'h44);
      cycle();
      drive(32'h40, 1, 1, 32'h40, 1, 32'h80, 1, 32'h80);
      cycle();
      drive(32'h40, 1, 1, 32'h40, 0, 32'h0, 1, 32'h80);
      cycle();
      idle(32'h40);
      #1;
      check_val("hyst_st_t", {31'b0, pred_taken}, 32'd1);
      cycle();

      // Stall gating on 0x44: allocate (10), then a stalled not-taken branch steps once to 01
      drive(32'h44, 1, 1, 32'h44, 1, 32'h100, 0, 32'h48);
      cycle();
      for (int k = 0; k < 4; k++) begin
         drive(32'h44, 1, (k == 3), 32'h44, 0, 32'h0, 1, 32'h100);
         #1;
         check_val("stall_misp", {31'b0, mispredict}, 32'd1);
         cycle();
      end
      idle(32'h44);
      #1;
      check_val("stall_one_step", {31'b0, pred_taken}, 32'd0);
      cycle();
      drive(32'h44, 1, 1, 32'h44, 1, 32'h100, 0, 32'h48);
      cycle();
      idle(32'h44);
      #1;
      check_val("stall_recover", {31'b0, pred_taken}, 32'd1);
      cycle();

      // Aliasing: 0x80 shares the slot with 0x40 and evicts it
      drive(32'h80, 1, 1, 32'h80, 1, 32'h200, 0, 32'h84);
      cycle();
      idle(32'h40);
      #1;
      check_val("alias_evicted", pred_target, 32'h44);
      cycle();
      idle(32'h80);
      #1;
      check_val("alias_hit", pred_target, 32'h200);
      cycle();
      drive(32'h80, 1, 1, 32'h80, 1, 32'h300, 1, 32'h200);
      #1;
      check_val("wrong_target", {31'b0, mispredict}, 32'd1);
      cycle();

      // Fall-through wraps at the top of the address space
      idle(32'hFFFF_FFFC);
      #1;
      check_val("wrap_target", pred_target, 32'h0);
      cycle();

      // Reset wins over a simultaneous commit
      RST = 1'b1;
      drive(32'h48, 1, 1, 32'h48, 1, 32'h500, 0, 32'h4C);
      cycle();
      RST = 1'b0;
      idle(32'h48);
      #1;
      check_val("rst_wins", {31'b0, pred_taken}, 32'd0);
      cycle();

`ifdef BP_STATS_EN
      RST = 1'b1;
      idle(32'h0);
      cycle();
      RST = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (k == 1)      drive(32'h0, 1, 1, 32'h50, 1, 32'h90, 0, 32'h54);
         else if (k == 3) drive(32'h0, 1, 0, 32'h54, 1, 32'h94, 0, 32'h58);
         else if (k == 4) drive(32'h0, 1, 1, 32'h54, 1, 32'h94, 0, 32'h58);
         else             idle(32'h0);
         cycle();
      end
      check_val("stat_lookups10", stat_lookups, 32'd10);
      check_val("stat_mispred2",  stat_mispred, 32'd2);
      RST = 1'b1;
      idle(32'h0);
      cycle();
      RST = 1'b0;
      check_val("stat_lookups_rst", stat_lookups, 32'd0);
      check_val("stat_mispred_rst", stat_mispred, 32'd0);
`endif

      // Randomized traffic over a small address window so hits and aliasing are frequent
      for (int k = 0; k < 600; k++) begin
         logic [31:0] fpc, rpc, rtgt;
         logic        rt;
         RST = ($urandom_range(0, 99) == 0);
         fpc = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC
               : ({26'b0, 6'($urandom_range(0, 63))} << 2) | 32'($urandom_range(0, 3));
         rpc = {26'b0, 6'($urandom_range(0, 63))} << 2;
         rt = 1'($urandom_range(0, 1));
         rtgt = 32'h1000 | ({29'b0, 3'($urandom_range(0, 7))} << 2);
         if ($urandom_range(0, 3) != 0)
            drive(fpc, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), rpc, rt, rtgt,
                  m_pred_taken(rpc), m_pred_target(rpc));
         else
            drive(fpc, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), rpc, rt, rtgt,
                  1'($urandom_range(0, 1)), 32'h1000 | ({29'b0, 3'($urandom_range(0, 7))} << 2));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
